cond_op_arbiter: RTL and testbench

- Round-robin arbiter that shares one conditional-clamp datapath between two 4-bit requesters.
- Each requester uses a valid/ready handshake.
- The winning sample is transformed, registered in a single output stage, and tagged with its source.
- Per-requester saturating grant counters support debug and fairness checks.

---
 rtl/cond_op_pkg.sv | 19 +
 rtl/cond_op_arbiter_if.sv | 31 +++
 rtl/cond_clamp.sv | 20 ++
 rtl/cond_op_arbiter.sv | 92 +++++++++
 tb/tb_cond_op_arbiter.sv | 254 +++++++++++++++++++++++++
 5 files changed

// File: rtl/cond_op_pkg.sv
// Shared defaults, FSM encoding and result record for the conditional-clamp arbiter.
package cond_op_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_LIMIT = 9;
    localparam int DEF_CNT_W = 8;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    typedef struct packed {
        logic [DEF_WIDTH-1:0] data;
        logic                 clamped;
        logic                 src;
    } result_t;

endpackage

// File: rtl/cond_op_arbiter_if.sv
// Requester, result and debug-counter signals of the conditional-clamp arbiter.
interface cond_op_arbiter_if #(
    parameter int WIDTH = 4,
    parameter int CNT_W = 8
);
    logic             req0_valid;
    logic [WIDTH-1:0] req0_data;
    logic             req0_ready;
    logic             req1_valid;
    logic [WIDTH-1:0] req1_data;
    logic             req1_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_src;
    logic             out_clamped;
    logic             out_ready;
    logic [CNT_W-1:0] gnt_cnt0;
    logic [CNT_W-1:0] gnt_cnt1;

    modport slave (
        input  req0_valid, req0_data, req1_valid, req1_data, out_ready,
        output req0_ready, req1_ready, out_valid, out_data, out_src, out_clamped,
        output gnt_cnt0, gnt_cnt1
    );

    modport master (
        output req0_valid, req0_data, req1_valid, req1_data, out_ready,
        input  req0_ready, req1_ready, out_valid, out_data, out_src, out_clamped,
        input  gnt_cnt0, gnt_cnt1
    );
endinterface

// File: rtl/cond_clamp.sv
// Combinational clamp: saturate data at LIMIT and flag when the input exceeded it.
module cond_clamp
    import cond_op_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LIMIT = DEF_LIMIT
) (
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] result,
    output logic             clamped
);
    if (LIMIT < 0 || LIMIT >= (2 ** WIDTH)) begin : g_limit_chk
        $error("cond_clamp: LIMIT %0d does not fit in %0d bits", LIMIT, WIDTH);
    end

    localparam logic [WIDTH-1:0] LIMIT_W = WIDTH'(LIMIT);

    assign clamped = (data > LIMIT_W);
    assign result  = clamped ? LIMIT_W : data;
endmodule

// File: rtl/cond_op_arbiter.sv
// Round-robin arbiter sharing one clamp datapath between two requesters,
// with a single pipelined output register and saturating grant counters.
module cond_op_arbiter
    import cond_op_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int LIMIT = DEF_LIMIT,
    parameter int CNT_W = DEF_CNT_W
) (
    input logic             clk,
    input logic             rst_n,
    cond_op_arbiter_if.slave bus
);
    // state    | meaning
    // ST_EMPTY | output register holds nothing, out_valid=0
    // ST_FULL  | output register holds a result, out_valid=1

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             clamped;
        logic             src;
    } res_t;

    state_e           state_q, state_d;
    logic             prio_q, prio_d;
    res_t             res_q, res_d;
    logic [CNT_W-1:0] cnt0_q, cnt0_d;
    logic [CNT_W-1:0] cnt1_q, cnt1_d;

    logic             can_accept;
    logic             grant0, grant1;
    logic [WIDTH-1:0] sel_data;
    logic [WIDTH-1:0] clamp_data;
    logic             clamp_flag;

    // Consuming the held result frees the register in the same cycle.
    assign can_accept = (state_q == ST_EMPTY) | bus.out_ready;
    assign grant0 = can_accept & bus.req0_valid & (~bus.req1_valid | ~prio_q);
    assign grant1 = can_accept & bus.req1_valid & (~bus.req0_valid |  prio_q);
    assign sel_data = grant1 ? bus.req1_data : bus.req0_data;

    cond_clamp #(
        .WIDTH (WIDTH),
        .LIMIT (LIMIT)
    ) u_clamp (
        .data    (sel_data),
        .result  (clamp_data),
        .clamped (clamp_flag)
    );

    always_comb begin
        state_d = state_q;
        prio_d  = prio_q;
        res_d   = res_q;
        cnt0_d  = cnt0_q;
        cnt1_d  = cnt1_q;
        if (grant0 | grant1) begin
            res_d   = '{data: clamp_data, clamped: clamp_flag, src: grant1};
            state_d = ST_FULL;
            prio_d  = ~grant1;
            if (grant0 && cnt0_q != '1) cnt0_d = cnt0_q + CNT_W'(1);
            if (grant1 && cnt1_q != '1) cnt1_d = cnt1_q + CNT_W'(1);
        end else if (state_q == ST_FULL && bus.out_ready) begin
            state_d = ST_EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
            prio_q  <= 1'b0;
            res_q   <= '0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            state_q <= state_d;
            prio_q  <= prio_d;
            res_q   <= res_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
        end
    end

    assign bus.req0_ready  = grant0;
    assign bus.req1_ready  = grant1;
    assign bus.out_valid   = (state_q == ST_FULL);
    assign bus.out_data    = res_q.data;
    assign bus.out_src     = res_q.src;
    assign bus.out_clamped = res_q.clamped;
    assign bus.gnt_cnt0    = cnt0_q;
    assign bus.gnt_cnt1    = cnt1_q;
endmodule

// File: tb/tb_cond_op_arbiter.sv
// Scoreboard bench for cond_op_arbiter: directed stimulus queues expected results,
// a negedge monitor pops them on every output handshake.
module tb_cond_op_arbiter;
    import cond_op_pkg::*;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    result_t exp_q[$];

    cond_op_arbiter_if #(.WIDTH(4), .CNT_W(8)) b ();
    cond_op_arbiter_if #(.WIDTH(4), .CNT_W(2)) bs ();

    cond_op_arbiter #(.WIDTH(4), .LIMIT(9), .CNT_W(8)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b)
    );

    cond_op_arbiter #(.WIDTH(4), .LIMIT(9), .CNT_W(2)) u_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bs)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] d, input logic c, input logic s);
        exp_q.push_back(result_t'{data: d, clamped: c, src: s});
    endtask

    task automatic idle_inputs();
        b.req0_valid  = 1'b0;
        b.req1_valid  = 1'b0;
        b.out_ready   = 1'b1;
        bs.req0_valid = 1'b0;
        bs.req1_valid = 1'b0;
        bs.out_ready  = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        @(negedge clk);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    always @(negedge clk) begin
        result_t e;
        if (rst_n && b.out_valid && b.out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got data=%0d clamped=%0d src=%0d exp none",
                         b.out_data, b.out_clamped, b.out_src);
            end else begin
                e = exp_q.pop_front();
                if ({b.out_data, b.out_clamped, b.out_src} !== e) begin
                    errors++;
                    $display("FAIL sb_result got data=%0d clamped=%0d src=%0d exp data=%0d clamped=%0d src=%0d",
                             b.out_data, b.out_clamped, b.out_src, e.data, e.clamped, e.src);
                end
            end
        end
    end

    initial begin
        logic [3:0] vals [4];
        vals = '{4'd0, 4'd9, 4'd10, 4'd15};

        // Reset held with random inputs
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            b.req0_valid  = 1'($urandom_range(0, 1));
            b.req0_data   = 4'($urandom_range(0, 15));
            b.req1_valid  = 1'($urandom_range(0, 1));
            b.req1_data   = 4'($urandom_range(0, 15));
            b.out_ready   = 1'($urandom_range(0, 1));
            bs.req0_valid = 1'($urandom_range(0, 1));
            bs.req0_data  = 4'($urandom_range(0, 15));
            bs.req1_valid = 1'($urandom_range(0, 1));
            bs.req1_data  = 4'($urandom_range(0, 15));
            bs.out_ready  = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        check("rst_out_valid", b.out_valid, 0);
        check("rst_out_data", b.out_data, 0);
        check("rst_src_clamped", {b.out_src, b.out_clamped}, 0);
        check("rst_cnts", {b.gnt_cnt0, b.gnt_cnt1}, 0);
        idle_inputs();
        step();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_readies", {b.req0_ready, b.req1_ready}, 0);
        check("post_rst_valid", b.out_valid, 0);
        step();

        // Single requester streaming back-to-back
        push(4'd0, 1'b0, 1'b0);
        push(4'd9, 1'b0, 1'b0);
        push(4'd9, 1'b1, 1'b0);
        push(4'd9, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            b.req0_valid = 1'b1;
            b.req0_data  = vals[i];
            @(negedge clk);
            check("single_ready", b.req0_ready, 1);
            if (i > 0) check("single_out_valid", b.out_valid, 1);
            step();
        end
        b.req0_valid = 1'b0;
        @(negedge clk);
        check("single_cnt0", b.gnt_cnt0, 4);
        step();

        // Contention: alternating grants starting at requester 0
        do_reset();
        b.req0_valid = 1'b1;
        b.req0_data  = 4'd12;
        b.req1_valid = 1'b1;
        b.req1_data  = 4'd3;
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) push(4'd9, 1'b1, 1'b0);
            else            push(4'd3, 1'b0, 1'b1);
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("cont_ready0", b.req0_ready, (i % 2 == 0) ? 1 : 0);
            check("cont_ready1", b.req1_ready, (i % 2 == 1) ? 1 : 0);
            step();
        end
        b.req0_valid = 1'b0;
        b.req1_valid = 1'b0;
        @(negedge clk);
        check("cont_cnt0", b.gnt_cnt0, 5);
        check("cont_cnt1", b.gnt_cnt1, 5);
        step();

        // Backpressure: one grant, stall, then grant to the other side on consume
        b.out_ready  = 1'b0;
        b.req0_valid = 1'b1;
        b.req0_data  = 4'd12;
        b.req1_valid = 1'b1;
        b.req1_data  = 4'd3;
        push(4'd9, 1'b1, 1'b0);
        push(4'd3, 1'b0, 1'b1);
        @(negedge clk);
        check("bp_first_grant", {b.req0_ready, b.req1_ready}, 2'b10);
        step();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("bp_stall_readies", {b.req0_ready, b.req1_ready}, 2'b00);
            check("bp_hold_data", {b.out_valid, b.out_data, b.out_src}, {1'b1, 4'd9, 1'b0});
            step();
        end
        b.out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_grant", {b.req0_ready, b.req1_ready}, 2'b01);
        step();
        b.req0_valid = 1'b0;
        b.req1_valid = 1'b0;
        @(negedge clk);
        check("bp_second_src", b.out_src, 1);
        step();

        // Drain: priority must survive idle cycles
        b.out_ready  = 1'b0;
        b.req0_valid = 1'b1;
        b.req0_data  = 4'd7;
        push(4'd7, 1'b0, 1'b0);
        @(negedge clk);
        check("drain_grant", b.req0_ready, 1);
        step();
        b.req0_valid = 1'b0;
        @(negedge clk);
        check("drain_full", b.out_valid, 1);
        step();
        b.out_ready = 1'b1;
        @(negedge clk);
        step();
        @(negedge clk);
        check("drain_empty", b.out_valid, 0);
        check("drain_data_kept", b.out_data, 7);
        step();
        step();
        b.req0_valid = 1'b1;
        b.req0_data  = 4'd2;
        b.req1_valid = 1'b1;
        b.req1_data  = 4'd4;
        push(4'd4, 1'b0, 1'b1);
        @(negedge clk);
        check("drain_prio_kept", {b.req0_ready, b.req1_ready}, 2'b01);
        step();
        b.req0_valid = 1'b0;
        b.req1_valid = 1'b0;
        @(negedge clk);
        step();

        // Asynchronous reset while FULL discards the held result
        b.out_ready  = 1'b0;
        b.req0_valid = 1'b1;
        b.req0_data  = 4'd15;
        @(negedge clk);
        step();
        b.req0_valid = 1'b0;
        @(negedge clk);
        check("arst_pre_full", {b.out_valid, b.out_clamped}, 2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", b.out_valid, 0);
        check("arst_data", b.out_data, 0);
        check("arst_cnt0", b.gnt_cnt0, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        b.out_ready = 1'b1;

        // Saturation on the 2-bit counter instance
        bs.out_ready  = 1'b1;
        bs.req1_valid = 1'b1;
        bs.req1_data  = 4'd5;
        for (int i = 0; i < 6; i++) step();
        bs.req1_valid = 1'b0;
        @(negedge clk);
        check("sat_cnt1", bs.gnt_cnt1, 3);
        check("sat_cnt0", bs.gnt_cnt0, 0);
        step();

        check("sb_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
